// File: rtl/mode_sequencer.sv
// -----------------------------------------------------------------------------
// mode_sequencer
//   Drives the direction input of an external up/down counter so that it
//   bounces between low_lim and high_lim. Every reversal gives a one-cycle
//   turn pulse. Limits that are too close together (fewer than two steps
//   apart) park the block in an error state until enable drops.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   1 = run the bounce sequence, 0 = go back to idle
//   low_lim     in   [sz-1:0] lower turn point, unsigned
//   high_lim    in   [sz-1:0] upper turn point, unsigned
//   counter     in   [sz-1:0] current value of the downstream counter
//   mode        out  registered direction, 0 = up, 1 = down
//   turn        out  registered one-cycle pulse on each reversal
//   lim_err     out  registered, high while in the error state
//   turn_count  out  [7:0] saturating reversal count
//
// Configuration
//   MODE_SEQ_TURN_CNT_EN  defined   -> saturating reversal counter is built
//                         undefined -> turn_count is tied to zero
// -----------------------------------------------------------------------------
module mode_sequencer #(
  parameter int sz = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [sz-1:0] low_lim,
  input  logic [sz-1:0] high_lim,
  input  logic [sz-1:0] counter,
  output logic          mode,
  output logic          turn,
  output logic          lim_err,
  output logic [7:0]    turn_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [sz:0] ONE = (sz+1)'(1);
  localparam logic [sz:0] TWO = (sz+1)'(2);

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   turn_q, turn_d;
  logic   lim_err_q, lim_err_d;

  // All limit arithmetic is done one bit wider so low_lim+2 and
  // counter+1 cannot wrap for values near the top of the range.
  logic [sz:0] low_ext, high_ext, cnt_ext;
  logic        lim_ok, at_top, at_bot;

  assign low_ext  = {1'b0, low_lim};
  assign high_ext = {1'b0, high_lim};
  assign cnt_ext  = {1'b0, counter};

  assign lim_ok = (high_ext >= low_ext + TWO);
  // counter >= high_lim-1 written as counter+1 >= high_lim (no underflow).
  // Comparing one step early means the counter, which still moves once more
  // before it sees the new mode, tops out exactly on high_lim. Values past
  // the limit also satisfy the compare, so an overshoot turns immediately.
  assign at_top = (cnt_ext + ONE >= high_ext);
  assign at_bot = (cnt_ext <= low_ext + ONE);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    turn_d    = 1'b0;
    lim_err_d = lim_err_q;

    unique case (state_q)
      S_IDLE: begin
        mode_d    = 1'b0;
        lim_err_d = 1'b0;
        if (enable) begin
          if (lim_ok) begin
            state_d = S_UP;
          end else begin
            state_d   = S_ERR;
            lim_err_d = 1'b1;
          end
        end
      end

      S_UP, S_DOWN: begin
        if (!enable) begin
          state_d = S_IDLE;
          mode_d  = 1'b0;
        end else if (!lim_ok) begin
          // Direction is frozen where it was when the limits went bad.
          state_d   = S_ERR;
          lim_err_d = 1'b1;
        end else if (!turn_q) begin
          // A turn is never issued in the cycle right after another one,
          // which keeps turn from being high two cycles in a row even if
          // the counter is yanked across both limits.
          if (state_q == S_UP && at_top) begin
            state_d = S_DOWN;
            mode_d  = 1'b1;
            turn_d  = 1'b1;
          end else if (state_q == S_DOWN && at_bot) begin
            state_d = S_UP;
            mode_d  = 1'b0;
            turn_d  = 1'b1;
          end
        end
      end

      S_ERR: begin
        lim_err_d = 1'b1;
        if (!enable) begin
          state_d   = S_IDLE;
          mode_d    = 1'b0;
          lim_err_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mode_d    = 1'b0;
        lim_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      turn_q    <= 1'b0;
      lim_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      turn_q    <= turn_d;
      lim_err_q <= lim_err_d;
    end
  end

  assign mode    = mode_q;
  assign turn    = turn_q;
  assign lim_err = lim_err_q;

`ifdef MODE_SEQ_TURN_CNT_EN
  logic [7:0] turn_cnt_q, turn_cnt_d;

  // Counts on the same edge the turn pulse is registered, so the count
  // already includes a pulse while that pulse is visible.
  always_comb begin
    turn_cnt_d = turn_cnt_q;
    if (turn_d && turn_cnt_q != 8'hFF) turn_cnt_d = turn_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) turn_cnt_q <= 8'd0;
    else       turn_cnt_q <= turn_cnt_d;
  end

  assign turn_count = turn_cnt_q;
`else
  assign turn_count = 8'd0;
`endif

endmodule

// File: tb/tb_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mode_sequencer
//   Pairs mode_sequencer with an 8-bit up/down counter modelled in the bench
//   and compares every output each cycle against a behavioural model of the
//   bounce rules. Directed scenarios cover the basic bounce, bad limits,
//   disable mid-run, overshoot, reset mid-run and count saturation; a random
//   phase then mixes resets, enable toggles, limit changes and counter jumps.
// -----------------------------------------------------------------------------
module tb_mode_sequencer;

  localparam int IDLE = 0, UP = 1, DOWN = 2, ERR = 3;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [7:0] low_lim, high_lim, counter;
  logic       mode, turn, lim_err;
  logic [7:0] turn_count;

  int n_chk = 0, n_fail = 0;

  // behavioural model state
  int m_st = IDLE;
  bit m_mode = 0, m_turn = 0;
  int m_cnt = 0;
  int nturns = 0;

  mode_sequencer #(.sz(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .low_lim(low_lim), .high_lim(high_lim), .counter(counter),
    .mode(mode), .turn(turn), .lim_err(lim_err), .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from the inputs seen at this edge, step the external
  // counter by the direction that was in force before the edge, then check.
  task automatic tick();
    int  nst, ncnt;
    bit  nmode, nturn, ok;
    ok    = int'(high_lim) >= int'(low_lim) + 2;
    nst   = m_st;
    nmode = m_mode;
    nturn = 0;
    ncnt  = m_cnt;
    if (reset) begin
      nst = IDLE; nmode = 0; ncnt = 0;
    end else begin
      case (m_st)
        IDLE: if (enable) nst = ok ? UP : ERR;
        UP, DOWN: begin
          if (!enable) begin
            nst = IDLE; nmode = 0;
          end else if (!ok) begin
            nst = ERR;
          end else if (!m_turn && m_st == UP && int'(counter) >= int'(high_lim) - 1) begin
            nst = DOWN; nmode = 1; nturn = 1;
          end else if (!m_turn && m_st == DOWN && int'(counter) <= int'(low_lim) + 1) begin
            nst = UP; nmode = 0; nturn = 1;
          end
        end
        default: if (!enable) begin nst = IDLE; nmode = 0; end
      endcase
`ifdef MODE_SEQ_TURN_CNT_EN
      if (nturn && ncnt < 255) ncnt++;
`endif
    end
    @(posedge clk);
    #1;
    counter = m_mode ? counter - 8'd1 : counter + 8'd1;
    m_st = nst; m_mode = nmode; m_turn = nturn; m_cnt = ncnt;
    if (nturn) nturns++;
    chk("mode", int'(mode), int'(m_mode));
    chk("turn", int'(turn), int'(m_turn));
    chk("lim_err", int'(lim_err), (m_st == ERR) ? 1 : 0);
    chk("turn_count", int'(turn_count), m_cnt);
  endtask

  initial begin
    int cyc, seen, base, exp_tc;

    reset = 1; enable = 0; low_lim = 8'd10; high_lim = 8'd20; counter = 8'd0;
    tick(); tick();
    chk("rst_mode", int'(mode), 0);
    chk("rst_count", int'(turn_count), 0);

    // basic bounce 10..20 from counter 0
    reset = 0; enable = 1; counter = 8'd0; nturns = 0;
    cyc = 0;
    while (nturns < 1 && cyc < 100) begin tick(); cyc++; end
    chk("first_turn_cnt", int'(counter), 20);
    chk("first_turn_mode", int'(mode), 1);
    cyc = 0;
    while (nturns < 2 && cyc < 100) begin tick(); cyc++; end
    chk("second_turn_cnt", int'(counter), 10);
    chk("second_turn_mode", int'(mode), 0);

    // run to turn 7, catch DOWN at counter 15, then reset
    cyc = 0;
    while (!(nturns >= 7 && m_st == DOWN && counter == 8'd15) && cyc < 400) begin
      tick(); cyc++;
    end
    chk("mid_down_reached", cyc < 400 ? 1 : 0, 1);
`ifdef MODE_SEQ_TURN_CNT_EN
    exp_tc = 7;
`else
    exp_tc = 0;
`endif
    chk("tc_before_rst", int'(turn_count), exp_tc);
    reset = 1;
    tick();
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_lim_err", int'(lim_err), 0);
    chk("rst_mid_turn_count", int'(turn_count), 0);
    reset = 0;

    // disable while in DOWN at counter 15
    counter = 8'd0;
    cyc = 0;
    while (!(m_st == DOWN && counter == 8'd15) && cyc < 100) begin tick(); cyc++; end
    enable = 0;
    tick();
    chk("dis_mode", int'(mode), 0);
    chk("dis_turn", int'(turn), 0);

    // limits too close
    low_lim = 8'd10; high_lim = 8'd11; enable = 1;
    tick(); tick();
    chk("err_lim_err", int'(lim_err), 1);
    chk("err_mode", int'(mode), 0);
    enable = 0;
    tick();
    chk("err_exit", int'(lim_err), 0);

    // overshoot: counter jumps to 200 while in UP with high 20
    low_lim = 8'd10; high_lim = 8'd20; enable = 1; counter = 8'd0;
    tick(); tick(); tick();
    counter = 8'd200;
    tick();
    chk("over_mode", int'(mode), 1);
    seen = int'(turn);
    for (int i = 0; i < 20; i++) begin tick(); seen += int'(turn); end
    chk("over_turns", seen, 1);

    // random mix
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) reset = 1; else reset = 0;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) begin
        low_lim  = 8'($urandom_range(0, 250));
        high_lim = low_lim + 8'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) high_lim = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 24) == 0) counter = 8'($urandom_range(0, 255));
      tick();
    end

    // saturation: 300 reversals on a tight 10..13 bounce
    reset = 1; enable = 1; low_lim = 8'd10; high_lim = 8'd13;
    tick();
    reset = 0; counter = 8'd10;
    base = nturns;
    cyc = 0;
    while (nturns - base < 300 && cyc < 3000) begin tick(); cyc++; end
    chk("sat_reached", nturns - base, 300);
`ifdef MODE_SEQ_TURN_CNT_EN
    exp_tc = 255;
`else
    exp_tc = 0;
`endif
    chk("sat_count", int'(turn_count), exp_tc);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
